// File: rtl/dec_result_collector.sv
// Collects out-of-order 1-bit classifier results by sample ID and streams them
// back in ascending ID order, packed 8 results per byte, over a valid/ready sink.
module dec_result_collector #(
    parameter int ID_W   = 8,
    parameter int PACK_W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear,
    input  logic            start,
    input  logic [ID_W:0]   num_samples,
    input  logic            res_valid,
    input  logic [ID_W-1:0] res_id,
    input  logic            res_bit,
    output logic            out_valid,
    output logic [7:0]      out_data,
    output logic            out_last,
    input  logic            out_ready,
    output logic            done,
    output logic            err_dup
);

    localparam int DEPTH = 1 << ID_W;
    localparam int GW    = ID_W - 3;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state_q, state_d;
    logic [ID_W:0]     n_q;
    logic [ID_W:0]     n_m1;
    logic [GW-1:0]     g_q;
    logic [GW-1:0]     last_g;
    logic              last_sent_q;
    logic [DEPTH-1:0]  got_q, got_d;
    logic [DEPTH-1:0]  res_bits_q, res_bits_d;
    logic [PACK_W-1:0] pack_word;
    logic [ID_W-1:0]   grp_id;
    logic              grp_ready;
    logic              load;
    logic              accept;
    logic              dup;
    logic              clr_hit;

    assign n_m1   = n_q - 1'b1;
    assign last_g = n_m1[ID_W-1:3];
    assign accept = out_valid && out_ready;

    // IDs beyond the batch size never arrive, so they count as present and read as 0.
    always_comb begin
        pack_word = '0;
        grp_ready = 1'b1;
        grp_id    = '0;
        for (int i = 0; i < PACK_W; i++) begin
            grp_id = {g_q, 3'(i)};
            if ({1'b0, grp_id} < n_q) begin
                pack_word[i] = res_bits_q[grp_id];
                if (!got_q[grp_id])
                    grp_ready = 1'b0;
            end
        end
    end

    assign load = (state_q == RUN) && !last_sent_q && (!out_valid || out_ready)
                  && grp_ready && (g_q <= last_g);

    // A result landing in the group being unloaded belongs to the next batch, so it wins.
    always_comb begin
        got_d      = got_q;
        res_bits_d = res_bits_q;
        dup        = 1'b0;
        clr_hit    = load && (res_id[ID_W-1:3] == g_q);
        if (load) begin
            for (int i = 0; i < PACK_W; i++)
                got_d[{g_q, 3'(i)}] = 1'b0;
        end
        if (res_valid) begin
            if (!got_q[res_id] || clr_hit) begin
                got_d[res_id]      = 1'b1;
                res_bits_d[res_id] = res_bit;
            end else begin
                dup = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start) state_d = (num_samples == '0) ? DONE : RUN;
            RUN:  if (accept && out_last) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign done = (state_q == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else if (clear)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            got_q       <= '0;
            g_q         <= '0;
            n_q         <= '0;
            last_sent_q <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_last    <= 1'b0;
            err_dup     <= 1'b0;
        end else if (clear) begin
            got_q       <= '0;
            g_q         <= '0;
            n_q         <= '0;
            last_sent_q <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_last    <= 1'b0;
            err_dup     <= 1'b0;
        end else begin
            got_q <= got_d;
            if (dup)
                err_dup <= 1'b1;
            if (state_q == IDLE && start) begin
                n_q         <= num_samples;
                g_q         <= '0;
                last_sent_q <= 1'b0;
            end
            if (load) begin
                out_valid <= 1'b1;
                out_data  <= pack_word;
                out_last  <= (g_q == last_g);
                g_q       <= g_q + 1'b1;
                if (g_q == last_g)
                    last_sent_q <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    // Result bits are qualified by got, so they need no reset.
    always_ff @(posedge clk) begin
        if (!clear)
            res_bits_q <= res_bits_d;
    end

endmodule
